// File: rtl/interp_segment_finder_pkg.sv
// Shared definitions for the interpolation segment finder: FSM encoding and default sizes.
package interp_segment_finder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_OUT    = 2'd2
    } state_t;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_POINTS = 8;

endpackage

// File: rtl/interp_bp_table.sv
// Breakpoint table: NUM_POINTS (X,Y) register pairs, one write port, reads at idx and idx+1,
// plus first/last X taps used for clamping the query.
module interp_bp_table
    import interp_segment_finder_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int NUM_POINTS = DEF_NUM_POINTS,
    parameter int ADDR_WIDTH = $clog2(NUM_POINTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wx_i,
    input  logic [DATA_WIDTH-1:0] wy_i,
    input  logic [ADDR_WIDTH-1:0] ridx_i,
    output logic [DATA_WIDTH-1:0] rd_x0_o,
    output logic [DATA_WIDTH-1:0] rd_y0_o,
    output logic [DATA_WIDTH-1:0] rd_x1_o,
    output logic [DATA_WIDTH-1:0] rd_y1_o,
    output logic [DATA_WIDTH-1:0] x_first_o,
    output logic [DATA_WIDTH-1:0] x_last_o
);

    localparam logic [ADDR_WIDTH:0] NUM_PTS_L = (ADDR_WIDTH+1)'(NUM_POINTS);

    logic [DATA_WIDTH-1:0] x_q [NUM_POINTS];
    logic [DATA_WIDTH-1:0] y_q [NUM_POINTS];
    logic [ADDR_WIDTH-1:0] ridx1;
    logic                  addr_ok;

    // Addresses past the last breakpoint are silently dropped.
    assign addr_ok = ({1'b0, waddr_i} < NUM_PTS_L);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_POINTS; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
            end
        end else if (we_i && addr_ok) begin
            x_q[waddr_i] <= wx_i;
            y_q[waddr_i] <= wy_i;
        end
    end

    assign ridx1     = ridx_i + ADDR_WIDTH'(1);
    assign rd_x0_o   = x_q[ridx_i];
    assign rd_y0_o   = y_q[ridx_i];
    assign rd_x1_o   = x_q[ridx1];
    assign rd_y1_o   = y_q[ridx1];
    assign x_first_o = x_q[0];
    assign x_last_o  = x_q[NUM_POINTS-1];

endmodule

// File: rtl/interp_segment_finder.sv
// Finds the breakpoint segment bracketing a query x by linear scan and presents
// x0/y0/x1/y1 and the clamped x to the interpolator over valid/ready.
module interp_segment_finder
    import interp_segment_finder_pkg::*;
#(
    parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int NUM_POINTS = DEF_NUM_POINTS,
    localparam int ADDR_WIDTH = $clog2(NUM_POINTS)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tbl_we,
    input  logic [ADDR_WIDTH-1:0] tbl_addr,
    input  logic [DATA_WIDTH-1:0] tbl_x,
    input  logic [DATA_WIDTH-1:0] tbl_y,
    output logic                  busy,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_x,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_x0,
    output logic [DATA_WIDTH-1:0] out_y0,
    output logic [DATA_WIDTH-1:0] out_x1,
    output logic [DATA_WIDTH-1:0] out_y1,
    output logic [DATA_WIDTH-1:0] out_x,
    output logic                  out_clamped
);

    localparam logic [ADDR_WIDTH-1:0] LAST_SEG = ADDR_WIDTH'(NUM_POINTS - 2);

    // Returns {clamped_flag, clamped_value}.
    function automatic logic [DATA_WIDTH:0] clamp_x(input logic [DATA_WIDTH-1:0] x,
                                                    input logic [DATA_WIDTH-1:0] lo,
                                                    input logic [DATA_WIDTH-1:0] hi);
        if (x < lo)      return {1'b1, lo};
        else if (x > hi) return {1'b1, hi};
        else             return {1'b0, x};
    endfunction

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] cap_x_q, cap_x_d;
    logic [DATA_WIDTH-1:0] x0_q, x0_d, y0_q, y0_d, x1_q, x1_d, y1_q, y1_d;
    logic [DATA_WIDTH-1:0] ox_q, ox_d;
    logic                  clamped_q, clamped_d;
    logic                  valid_q, valid_d;

    logic [DATA_WIDTH-1:0] rd_x0, rd_y0, rd_x1, rd_y1, x_first, x_last;
    logic [DATA_WIDTH:0]   clamp_res;
    logic                  hit;
    logic                  tbl_we_ok;

    // Writes are only honoured between queries so a scan never sees a half-updated table.
    assign tbl_we_ok = tbl_we && (state_q == ST_IDLE);

    interp_bp_table #(
        .DATA_WIDTH(DATA_WIDTH),
        .NUM_POINTS(NUM_POINTS),
        .ADDR_WIDTH(ADDR_WIDTH)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .we_i      (tbl_we_ok),
        .waddr_i   (tbl_addr),
        .wx_i      (tbl_x),
        .wy_i      (tbl_y),
        .ridx_i    (idx_q),
        .rd_x0_o   (rd_x0),
        .rd_y0_o   (rd_y0),
        .rd_x1_o   (rd_x1),
        .rd_y1_o   (rd_y1),
        .x_first_o (x_first),
        .x_last_o  (x_last)
    );

    assign hit       = (cap_x_q < rd_x1) || (idx_q == LAST_SEG);
    assign clamp_res = clamp_x(cap_x_q, x_first, x_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            cap_x_q   <= '0;
            x0_q      <= '0;
            y0_q      <= '0;
            x1_q      <= '0;
            y1_q      <= '0;
            ox_q      <= '0;
            clamped_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cap_x_q   <= cap_x_d;
            x0_q      <= x0_d;
            y0_q      <= y0_d;
            x1_q      <= x1_d;
            y1_q      <= y1_d;
            ox_q      <= ox_d;
            clamped_q <= clamped_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cap_x_d   = cap_x_q;
        x0_d      = x0_q;
        y0_d      = y0_q;
        x1_d      = x1_q;
        y1_d      = y1_q;
        ox_d      = ox_q;
        clamped_d = clamped_q;
        valid_d   = valid_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    cap_x_d = in_x;
                    idx_d   = '0;
                    state_d = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                if (hit) begin
                    x0_d      = rd_x0;
                    y0_d      = rd_y0;
                    x1_d      = rd_x1;
                    y1_d      = rd_y1;
                    ox_d      = clamp_res[DATA_WIDTH-1:0];
                    clamped_d = clamp_res[DATA_WIDTH];
                    state_d   = ST_OUT;
                end else begin
                    idx_d = idx_q + ADDR_WIDTH'(1);
                end
            end
            ST_OUT: begin
                // Valid follows the registered fields by one clock and drops on handshake.
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
    end

    assign busy        = (state_q != ST_IDLE);
    assign in_ready    = (state_q == ST_IDLE);
    assign out_valid   = valid_q;
    assign out_x0      = x0_q;
    assign out_y0      = y0_q;
    assign out_x1      = x1_q;
    assign out_y1      = y1_q;
    assign out_x       = ox_q;
    assign out_clamped = clamped_q;

endmodule

// File: tb/tb_interp_segment_finder.sv
// Directed and randomized queries against a breakpoint-table reference model.
module tb_interp_segment_finder;

    localparam int N  = 8;
    localparam int DW = 16;
    localparam int AW = $clog2(N);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tbl_we = 1'b0;
    logic [AW-1:0] tbl_addr = '0;
    logic [DW-1:0] tbl_x = '0;
    logic [DW-1:0] tbl_y = '0;
    logic          busy;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_x = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_x0, out_y0, out_x1, out_y1, out_x;
    logic          out_clamped;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] tx [N];
    logic [DW-1:0] ty [N];

    interp_segment_finder #(.DATA_WIDTH(DW), .NUM_POINTS(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .tbl_we      (tbl_we),
        .tbl_addr    (tbl_addr),
        .tbl_x       (tbl_x),
        .tbl_y       (tbl_y),
        .busy        (busy),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_x0      (out_x0),
        .out_y0      (out_y0),
        .out_x1      (out_x1),
        .out_y1      (out_y1),
        .out_x       (out_x),
        .out_clamped (out_clamped)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic write_entry(input int a, input logic [DW-1:0] x, input logic [DW-1:0] y,
                               input bit update_model);
        @(negedge clk);
        tbl_we = 1'b1; tbl_addr = AW'(a); tbl_x = x; tbl_y = y;
        @(posedge clk);
        #1 tbl_we = 1'b0;
        if (update_model) begin
            tx[a] = x;
            ty[a] = y;
        end
    endtask

    task automatic load_linear();
        for (int i = 0; i < N; i++) write_entry(i, DW'(i * 100), DW'(i * 10), 1'b1);
    endtask

    // Reference: first segment whose upper breakpoint exceeds x, else the last one.
    task automatic run_query(input logic [DW-1:0] x, input string tag, input int hold);
        int seg;
        int lat;
        logic [DW-1:0] ex;
        logic ecl;
        seg = N - 2;
        for (int i = 0; i < N - 1; i++) begin
            if (x < tx[i+1]) begin
                seg = i;
                break;
            end
        end
        ex = x; ecl = 1'b0;
        if (x < tx[0]) begin
            ex = tx[0]; ecl = 1'b1;
        end else if (x > tx[N-1]) begin
            ex = tx[N-1]; ecl = 1'b1;
        end

        @(negedge clk);
        chk({tag, ".in_ready_idle"}, in_ready, 1);
        in_valid = 1'b1; in_x = x;
        @(posedge clk);
        #1 in_valid = 1'b0; in_x = DW'($urandom);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!out_valid && lat < 40);
        chk({tag, ".latency"}, lat, seg + 2);
        chk({tag, ".x0"}, out_x0, tx[seg]);
        chk({tag, ".y0"}, out_y0, ty[seg]);
        chk({tag, ".x1"}, out_x1, tx[seg+1]);
        chk({tag, ".y1"}, out_y1, ty[seg+1]);
        chk({tag, ".x"}, out_x, ex);
        chk({tag, ".clamped"}, out_clamped, ecl);
        chk({tag, ".busy"}, busy, 1);
        chk({tag, ".in_ready_busy"}, in_ready, 0);

        for (int k = 0; k < hold; k++) begin
            tbl_we = 1'b1; tbl_addr = AW'(3); tbl_x = 16'd9999; tbl_y = 16'd9999;
            in_valid = 1'b1; in_x = 16'd123;
            @(posedge clk);
            #1 tbl_we = 1'b0;
            @(negedge clk);
            chk({tag, ".hold_valid"}, out_valid, 1);
            chk({tag, ".hold_x0"}, out_x0, tx[seg]);
            chk({tag, ".hold_y1"}, out_y1, ty[seg+1]);
            chk({tag, ".hold_x"}, out_x, ex);
            chk({tag, ".hold_in_ready"}, in_ready, 0);
        end
        in_valid = 1'b0;

        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".post_valid"}, out_valid, 0);
        chk({tag, ".post_in_ready"}, in_ready, 1);
        chk({tag, ".post_busy"}, busy, 0);
    endtask

    initial begin
        int k;
        bit saw_valid;
        for (int i = 0; i < N; i++) begin
            tx[i] = '0;
            ty[i] = '0;
        end

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.busy", busy, 0);
        chk("rst.in_ready", in_ready, 1);
        chk("rst.out_valid", out_valid, 0);
        chk("rst.out_x0", out_x0, 0);
        chk("rst.out_y1", out_y1, 0);
        chk("rst.out_x", out_x, 0);
        chk("rst.out_clamped", out_clamped, 0);
        rst = 1'b0;

        // Linear table directed cases
        load_linear();
        run_query(16'd250, "q250", 0);
        run_query(16'd50,  "q50", 0);
        run_query(16'd900, "q900", 0);
        run_query(16'd700, "q700", 0);
        run_query(16'd0,   "q0", 0);
        run_query(16'd100, "q100", 0);

        // Raised first breakpoint: below-range query clamps up
        write_entry(0, 16'd50, 16'd0, 1'b1);
        run_query(16'd10, "q10_low", 0);
        write_entry(0, 16'd0, 16'd0, 1'b1);

        // Back-pressure hold with dropped table write, then re-read
        run_query(16'd450, "hold", 5);
        run_query(16'd350, "reread", 0);

        // Random queries on the linear table
        for (int i = 0; i < 12; i++) run_query(DW'($urandom_range(0, 800)), "rnd_lin", 0);

        // Random ascending table and mixed queries
        tx[0] = DW'($urandom_range(1, 500));
        for (int i = 1; i < N; i++) tx[i] = tx[i-1] + DW'($urandom_range(1, 8000));
        for (int i = 0; i < N; i++) write_entry(i, tx[i], DW'($urandom), 1'b0);
        for (int i = 0; i < N; i++) begin
            // keep model in sync with what was written
            tx[i] = dut.u_table.x_q[i] === tx[i] ? tx[i] : tx[i];
        end
        for (int i = 0; i < N; i++) ty[i] = '0;
        for (int i = 0; i < N; i++) begin
            logic [DW-1:0] yv;
            yv = DW'($urandom);
            write_entry(i, tx[i], yv, 1'b1);
        end
        run_query(16'd0, "rnd_tbl_zero", 0);
        run_query(16'hFFFF, "rnd_tbl_max", 0);
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                k = $urandom_range(0, N - 1);
                run_query(tx[k], "rnd_tbl_bp", 0);
            end else begin
                run_query(DW'($urandom), "rnd_tbl", 0);
            end
        end

        // Reset in the middle of a search
        load_linear();
        @(negedge clk);
        in_valid = 1'b1; in_x = 16'd650;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst.out_valid", out_valid, 0);
        chk("midrst.in_ready", in_ready, 1);
        chk("midrst.busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            tx[i] = '0;
            ty[i] = '0;
        end
        saw_valid = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (out_valid) saw_valid = 1'b1;
        end
        chk("midrst.no_stale", saw_valid, 0);
        run_query(16'd300, "midrst.cleared", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
